// File: rtl/skolem_pkg.sv
// Shared types and constants for the bvsgt/bvurem inverse search block.
package skolem_pkg;

  localparam int SKOLEM_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    CHECK,
    DONE
  } state_t;

  // Largest positive W-bit two's-complement value, returned zero-extended to 16 bits.
  function automatic logic [15:0] signed_max(input int w);
    return 16'((32'd1 << (w - 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/urem_seq.sv
// Iterative restoring divider producing the unsigned remainder, one quotient bit per cycle.
// A zero divisor yields the dividend, since every trial subtraction of 0 succeeds.
module urem_seq
  import skolem_pkg::*;
#(
  parameter int W = SKOLEM_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem,
  output logic         rdy
);

  // One bit wider than the operands so the shifted partial remainder never wraps.
  logic [W:0]   r;
  logic [W:0]   d;
  logic [W-1:0] q;
  logic [4:0]   cnt;
  logic [W:0]   shifted;
  logic         ge;

  always_comb begin
    shifted = (r << 1) | (W + 1)'(q[W-1]);
    ge      = (shifted >= d);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r   <= '0;
      d   <= '0;
      q   <= '0;
      cnt <= '0;
    end else if (start) begin
      r   <= '0;
      d   <= {1'b0, divisor};
      q   <= dividend;
      cnt <= 5'(W);
    end else if (cnt != '0) begin
      r   <= ge ? shifted - d : shifted;
      q   <= {q[W-2:0], ge};
      cnt <= cnt - 5'd1;
    end
  end

  assign rem = r[W-1:0];
  assign rdy = (cnt == '0);

endmodule

// File: rtl/find_inv_bvsgt_bvurem_seq.sv
// Finds the smallest unsigned x with (x bvurem s) >s t by sequential candidate search.
// Optional SKOLEM_EARLY_EXIT_EN: a signed-max threshold skips the search (no witness can exist).
module find_inv_bvsgt_bvurem_seq
  import skolem_pkg::*;
#(
  parameter int W = SKOLEM_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [W-1:0] x
);

  state_t       state, next_state;
  logic [W-1:0] s_reg, t_reg, cand;
  logic [4:0]   iter;
  logic         div_start, div_rdy;
  logic [W-1:0] rem;
  logic         hit, last, early_exit;

`ifdef SKOLEM_EARLY_EXIT_EN
  localparam logic [15:0]  T_MAX_FULL = signed_max(W);
  localparam logic [W-1:0] T_MAX      = T_MAX_FULL[W-1:0];
  assign early_exit = (t == T_MAX);
`else
  assign early_exit = 1'b0;
`endif

  urem_seq #(.W(W)) u_urem (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (cand),
    .divisor  (s_reg),
    .rem      (rem),
    .rdy      (div_rdy)
  );

  assign hit  = div_rdy && ($signed(rem) > $signed(t_reg));
  assign last = (cand == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    div_start  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE:  if (start) next_state = early_exit ? DONE : LOAD;
      LOAD: begin
        busy       = 1'b1;
        div_start  = 1'b1;
        next_state = DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (iter == 5'(W - 1)) next_state = CHECK;
      end
      CHECK: begin
        busy       = 1'b1;
        next_state = (hit || last) ? DONE : LOAD;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands, candidate and result change only on acceptance or in CHECK; otherwise they hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg <= '0;
      t_reg <= '0;
      cand  <= '0;
      iter  <= '0;
      found <= 1'b0;
      x     <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          s_reg <= s;
          t_reg <= t;
          cand  <= '0;
          found <= 1'b0;
          x     <= '0;
        end
        LOAD:  iter <= '0;
        DIV:   iter <= iter + 5'd1;
        CHECK: begin
          if (hit) begin
            found <= 1'b1;
            x     <= cand;
          end else if (!last) begin
            cand <= cand + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_find_inv_bvsgt_bvurem_seq.sv
// Self-checking bench for find_inv_bvsgt_bvurem_seq at W=4: directed cases plus random operands.
module tb_find_inv_bvsgt_bvurem_seq;

  localparam int WB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [WB-1:0] s_in = '0;
  logic [WB-1:0] t_in = '0;
  logic          busy, done, found;
  logic [WB-1:0] x;

  int            errors = 0;
  int            checks = 0;
  logic          prev_found = 1'b0;
  logic [WB-1:0] prev_x = '0;

  find_inv_bvsgt_bvurem_seq #(.W(WB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .s     (s_in),
    .t     (t_in),
    .busy  (busy),
    .done  (done),
    .found (found),
    .x     (x)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: brute-force scan of all candidates with plain arithmetic.
  task automatic ref_model(input logic [WB-1:0] sv, input logic [WB-1:0] tv,
                           output logic f, output logic [WB-1:0] xo, output int lat);
    logic [WB-1:0] r4;
    int            k;
    f  = 1'b0;
    xo = '0;
    k  = (1 << WB) - 1;
    for (int i = (1 << WB) - 1; i >= 0; i--) begin
      r4 = (sv == 0) ? WB'(i) : WB'(i % int'(sv));
      if ($signed(r4) > $signed(tv)) begin
        f  = 1'b1;
        xo = WB'(i);
        k  = i;
      end
    end
    lat = (WB + 2) * (k + 1) + 1;
`ifdef SKOLEM_EARLY_EXIT_EN
    if (tv == 4'h7) lat = 1;
`endif
  endtask

  // Starts one search on the negedge after the previous done and checks result and latency.
  task automatic run(input logic [WB-1:0] sv, input logic [WB-1:0] tv, input bit glitch);
    logic          ef;
    logic [WB-1:0] ex;
    int            elat;
    int            c;
    ref_model(sv, tv, ef, ex, elat);
    @(negedge clk);
    check("idle_done_low", done, 0);
    check("held_found", found, prev_found);
    check("held_x", x, prev_x);
    start = 1'b1;
    s_in  = sv;
    t_in  = tv;
    @(negedge clk);
    start = 1'b0;
    s_in  = WB'($urandom);
    t_in  = WB'($urandom);
    c     = 1;
    check("busy_after_accept", busy, (elat == 1) ? 0 : 1);
    while (!done && c < 200) begin
      if (glitch && c == 3) begin
        start = 1'b1;
        s_in  = 4'd2;
        t_in  = 4'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("latency", c, elat);
    check("found", found, ef);
    check("x", x, ex);
    check("busy_in_done", busy, 0);
    prev_found = ef;
    prev_x     = ex;
  endtask

  initial begin
    int c;
    logic [WB-1:0] rs, rt;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_x", x, 0);
    rst = 1'b0;

    run(4'd3, 4'd0, 1'b0);
    run(4'd0, 4'd5, 1'b0);
    run(4'd4, 4'd2, 1'b0);
    run(4'd5, 4'hF, 1'b0);
    run(4'd2, 4'd7, 1'b0);

    // start during DONE must be ignored
    run(4'd4, 4'd2, 1'b0);
    start = 1'b1;
    s_in  = 4'd1;
    t_in  = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored_busy", busy, 0);
    check("done_start_ignored_found", found, prev_found);
    check("done_start_ignored_x", x, prev_x);

    // start pulsed while busy with different operands
    run(4'd3, 4'd0, 1'b1);

    // reset in the middle of candidate 2's divide
    @(negedge clk);
    start = 1'b1;
    s_in  = 4'd2;
    t_in  = 4'd6;
    @(negedge clk);
    start = 1'b0;
    c     = 1;
    while (c < 15) begin
      @(negedge clk);
      c++;
    end
    check("busy_mid_search", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_found", found, 0);
    check("midrst_x", x, 0);
    repeat (2) begin
      @(negedge clk);
      check("no_done_in_reset", done, 0);
    end
    rst        = 1'b0;
    prev_found = 1'b0;
    prev_x     = '0;
    run(4'd3, 4'd0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rs = WB'($urandom_range(0, 15));
      rt = WB'($urandom_range(0, 15));
      run(rs, rt, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/find_inv_bvsgt_bvurem_seq.md
FIND_INV_BVSGT_BVUREM_SEQ -- requirements
Module: find_inv_bvsgt_bvurem_seq

Interface
REQ-001 Parameter W, default 8, operand width in bits, legal range 2..16.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous assert, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 s  input  W  divisor operand; captured when start is accepted.
REQ-006 t  input  W  signed threshold; captured when start is accepted.
REQ-007 busy  output  1  high from the cycle after acceptance until done.
REQ-008 done  output  1  one-cycle pulse when a result is ready.
REQ-009 found  output  1  a witness exists; valid with done and held afterwards.
REQ-010 x  output  W  witness; valid when found=1, held until next acceptance.

Function
REQ-011 The block SHALL compute the smallest unsigned x with (x bvurem s) >s t, where bvurem by 0 returns x, and comparison is W-bit two's complement.
REQ-012 FSM states SHALL be IDLE, LOAD, DIV, CHECK and DONE.
- IDLE->LOAD on start; LOAD->DIV; DIV->CHECK after W iterations.
- CHECK->DONE on a hit or on the last candidate; otherwise CHECK->LOAD with the candidate incremented.
- DONE->IDLE unconditionally.
REQ-013 Candidates SHALL be evaluated in order 0,1,...,2^W-1, each taking W+2 cycles: LOAD 1, DIV W, CHECK 1.
REQ-014 done SHALL assert (W+2)*(k+1)+1 cycles after the accepting edge, where k is the hit index.
- No hit: k = 2^W-1 and found=0.
REQ-015 When found=0, x SHALL be driven to 0.
REQ-016 The remainder SHALL come from an iterative restoring divider, one quotient bit per cycle.
- Divider registers SHALL be W+1 bits so that no intermediate value wraps.
REQ-017 start asserted while busy or in DONE SHALL be ignored; s and t SHALL NOT be re-captured.
REQ-018 start may be asserted in the cycle after done; it SHALL then be accepted normally.
REQ-019 found and x SHALL hold their values from done until the next acceptance; busy=0 in IDLE and DONE.

Reset
REQ-020 On rst: state=IDLE, busy=0, done=0, found=0, x=0, and all divider/candidate registers=0, regardless of state.
REQ-021 A reset mid-search SHALL abandon the search with no done pulse.
- The first start after rst deasserts SHALL be accepted.

Configuration
REQ-022 Macro SKOLEM_EARLY_EXIT_EN.
- When defined: if captured t equals signed max (0 followed by W-1 ones), the FSM SHALL go IDLE->DONE with found=0, done one cycle after acceptance, and busy never asserted.
- When undefined: the full search of REQ-014 SHALL run, and the result is identical.

Structure
REQ-023 Package skolem_pkg SHALL hold the FSM state enum, the default width constant SKOLEM_W_DEF=8, and a signed-max helper function.
REQ-024 The divider SHALL be the sub-module urem_seq (parameter W; ports start, dividend, divisor, rem, rdy).
- urem_seq handles divisor 0 by returning the dividend.

Verification (W=4)
REQ-025 s=3, t=0 -> found=1, x=1, done 13 cycles after acceptance.
REQ-026 s=0, t=5 -> found=1, x=6 (remainder equals x); s=4, t=2 -> found=1, x=3.
REQ-027 s=5, t=0xF (-1) -> found=1, x=0, done 7 cycles after acceptance.
REQ-028 s=2, t=7 -> found=0, x=0.
- With SKOLEM_EARLY_EXIT_EN: done 1 cycle after acceptance.
- Without it: done 97 cycles after acceptance.
REQ-029 Assert rst during DIV of candidate 2 -> all outputs 0 at once, no done pulse; a subsequent start with s=3, t=0 gives found=1, x=1.
REQ-030 Pulse start with new s and t while busy -> the inputs are ignored and the result matches the original operands.
